// File: rtl/shift_add_mult_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : shift_add_mult_seq
// Description : Sequential shift-add multiplier, signed/unsigned per operation,
//               optional early exit once the remaining multiplier bits are zero.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult_seq #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_early_stop;
  logic             w_calc_stop;

  // Magnitude as WIDTH-bit unsigned: the most negative value maps to 2^(WIDTH-1).
  assign w_a_neg = is_signed & a[WIDTH-1];
  assign w_b_neg = is_signed & b[WIDTH-1];
  assign w_abs_a = w_a_neg ? ({WIDTH{1'b0}} - a) : a;
  assign w_abs_b = w_b_neg ? ({WIDTH{1'b0}} - b) : b;

  assign w_early_stop = (EARLY_EXIT != 0) && (mplier_q == '0);
  assign w_calc_stop  = (iter_q == ITER_LAST) || w_early_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      iter_q    <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      iter_q    <= iter_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    iter_d    = iter_q;
    neg_d     = neg_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, w_abs_a};
          mplier_d = w_abs_b;
          acc_d    = '0;
          iter_d   = '0;
          neg_d    = w_a_neg ^ w_b_neg;
          state_d  = S_CALC;
        end
      end

      S_CALC: begin
        if (w_calc_stop) begin
          state_d = S_FIX;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          iter_d   = iter_q + IW'(1);
        end
      end

      S_FIX: begin
        // Negating zero yields zero, so no sign-of-zero special case is needed.
        product_d = neg_q ? ({PW{1'b0}} - acc_q) : acc_q;
        state_d   = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mult_seq
// Description : Directed self-checking bench for shift_add_mult_seq, with one
//               early-exit instance and one fixed-iteration instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult_seq;

  logic        clk;
  logic        rst;
  logic        start_e;
  logic        start_f;
  logic        is_signed;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready_e, busy_e, done_e;
  logic        ready_f, busy_f, done_f;
  logic [15:0] prod_e, prod_f;

  int checks;
  int errors;

  shift_add_mult_seq #(.WIDTH(8), .EARLY_EXIT(1)) u_dut_ee (
    .clk       (clk),
    .rst       (rst),
    .start     (start_e),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .ready     (ready_e),
    .busy      (busy_e),
    .done      (done_e),
    .product   (prod_e)
  );

  shift_add_mult_seq #(.WIDTH(8), .EARLY_EXIT(0)) u_dut_full (
    .clk       (clk),
    .rst       (rst),
    .start     (start_f),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .ready     (ready_f),
    .busy      (busy_f),
    .done      (done_f),
    .product   (prod_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation; inputs are scrambled right after accept to prove capture.
  task automatic do_op(input bit ee, input logic [7:0] av, input logic [7:0] bv,
                       input logic sg, input logic [15:0] exp_p, input int exp_lat,
                       input string tag);
    int lat;
    @(negedge clk);
    a = av; b = bv; is_signed = sg;
    if (ee) start_e = 1'b1; else start_f = 1'b1;
    @(negedge clk);
    start_e = 1'b0; start_f = 1'b0;
    a = ~av; b = ~bv; is_signed = ~sg;
    chk({tag, "_busy"}, 32'(ee ? busy_e : busy_f), 32'd1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((ee ? done_e : done_f) === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_prod"}, 32'(ee ? prod_e : prod_f), 32'(exp_p));
    @(negedge clk);
    chk({tag, "_rdy_done"}, 32'(ee ? {ready_e, done_e} : {ready_f, done_f}), 32'b10);
  endtask

  initial begin
    int lat;
    checks = 0; errors = 0;
    rst = 1'b1; start_e = 1'b0; start_f = 1'b0;
    is_signed = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready_e), 32'd1);
    chk("rst_busy",  32'(busy_e),  32'd0);
    chk("rst_done",  32'(done_e),  32'd0);
    chk("rst_prod",  32'(prod_e),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(1'b1, 8'd13,  8'd11,  1'b0, 16'h008F, 6,  "u13x11");
    do_op(1'b0, 8'd255, 8'd255, 1'b0, 16'hFE01, 10, "full255x255");
    do_op(1'b0, 8'h80,  8'h80,  1'b1, 16'h4000, 10, "full_m128sq");
    do_op(1'b1, 8'hF9,  8'd5,   1'b1, 16'hFFDD, 5,  "s_m7x5");
    do_op(1'b1, 8'h80,  8'h80,  1'b1, 16'h4000, 10, "s_m128sq");
    do_op(1'b1, 8'h80,  8'h02,  1'b0, 16'h0100, 4,  "u80x02");
    do_op(1'b1, 8'h80,  8'h02,  1'b1, 16'hFF00, 4,  "s80x02");

    // start pulses during CALC and DONE must be ignored
    @(negedge clk);
    a = 8'd13; b = 8'd11; is_signed = 1'b0; start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; is_signed = 1'b1; start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    chk("hs_prod_hold", 32'(prod_e), 32'h0000FF00);
    chk("hs_busy", 32'(busy_e), 32'd1);
    lat = 0;
    for (int i = 3; i <= 40; i++) begin
      @(negedge clk);
      if (done_e === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("hs_lat", 32'(lat), 32'd6);
    chk("hs_prod", 32'(prod_e), 32'h008F);
    a = 8'd3; b = 8'd3; start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    chk("hs_done_ignored_ready", 32'(ready_e), 32'd1);
    chk("hs_done_ignored_prod", 32'(prod_e), 32'h008F);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    a = 8'd255; b = 8'd255; is_signed = 1'b0; start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy_pre", 32'(busy_e), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(ready_e), 32'd1);
    chk("arst_busy",  32'(busy_e),  32'd0);
    chk("arst_done",  32'(done_e),  32'd0);
    chk("arst_prod",  32'(prod_e),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b1, 8'd6, 8'd7, 1'b0, 16'd42, 5, "after_rst_6x7");

    do_op(1'b1, 8'd5, 8'd0,   1'b0, 16'h0000, 2, "b_zero");
    do_op(1'b1, 8'd0, 8'hFF,  1'b1, 16'h0000, 3, "a_zero_neg");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
